// File: rtl/faiz_hakem_if.sv
// Request/accept/result bundle between the regional requesters and the rate arbiter.
interface faiz_hakem_if #(
    parameter int unsigned BOLGE_SAYISI = 4
);
    localparam int unsigned BW = (BOLGE_SAYISI > 1) ? $clog2(BOLGE_SAYISI) : 1;

    logic [BOLGE_SAYISI-1:0]   istek;
    logic [4*BOLGE_SAYISI-1:0] enflasyon;
    logic [BOLGE_SAYISI-1:0]   kabul;
    logic                      faiz_gecerli;
    logic [BW-1:0]             faiz_bolge;
    logic [5:0]                faiz;
    logic                      mesgul;

    modport master (
        output istek,
        output enflasyon,
        input  kabul,
        input  faiz_gecerli,
        input  faiz_bolge,
        input  faiz,
        input  mesgul
    );

    modport slave (
        input  istek,
        input  enflasyon,
        output kabul,
        output faiz_gecerli,
        output faiz_bolge,
        output faiz,
        output mesgul
    );
endinterface

// File: rtl/faiz_hakem.sv
// Round-robin arbiter sharing one multi-cycle interest-rate datapath among regions.
// Each region keeps its last three inflation samples and its last computed rate.
module faiz_hakem #(
    parameter int unsigned BOLGE_SAYISI = 4,
    parameter int unsigned FAIZ_MARJ    = 2
) (
    input logic        saat,
    input logic        reset,
    faiz_hakem_if.slave bus
);
    localparam int unsigned BW = (BOLGE_SAYISI > 1) ? $clog2(BOLGE_SAYISI) : 1;

    typedef enum logic [2:0] {StBosta, StCarp1, StCarp2, StBol, StSonuc} state_e;

    state_e                  state_q;
    logic [BW-1:0]           g_q;
    logic [BW-1:0]           ptr_q;
    logic [20:0]             p_q;
    logic [3:0]              h0_q   [BOLGE_SAYISI];
    logic [3:0]              h1_q   [BOLGE_SAYISI];
    logic [3:0]              h2_q   [BOLGE_SAYISI];
    logic [5:0]              rate_q [BOLGE_SAYISI];
    logic [BOLGE_SAYISI-1:0] kabul_q;
    logic                    gecerli_q;
    logic [BW-1:0]           bolge_q;
    logic [5:0]              faiz_q;
    logic                    mesgul_q;

    logic [3:0]              samp [BOLGE_SAYISI];
    logic [BW-1:0]           grant;
    logic                    grant_valid;
    logic [BW-1:0]           cand;
    int unsigned             idx;
    logic [20:0]             fac0, fac1, fac2;
    logic [20:0]             quot;
    logic [5:0]              rate_new;
    logic                    all_nz;
    logic [BW-1:0]           ptr_next;

    always_comb begin
        for (int i = 0; i < int'(BOLGE_SAYISI); i++) begin
            samp[i] = bus.enflasyon[4*i +: 4];
        end
    end

    // First requester at or after the pointer, scanning cyclically.
    always_comb begin
        grant       = '0;
        grant_valid = 1'b0;
        idx         = 0;
        cand        = '0;
        for (int unsigned i = 0; i < BOLGE_SAYISI; i++) begin
            idx  = (32'(ptr_q) + i) % BOLGE_SAYISI;
            cand = BW'(idx);
            if (!grant_valid && bus.istek[cand]) begin
                grant_valid = 1'b1;
                grant       = cand;
            end
        end
        ptr_next = (grant == BW'(BOLGE_SAYISI - 1)) ? '0 : grant + BW'(1);
    end

    always_comb begin
        fac0     = 21'(h0_q[g_q]) + 21'd100;
        fac1     = 21'(h1_q[g_q]) + 21'd100;
        fac2     = 21'(h2_q[g_q]) + 21'd100;
        quot     = (p_q / 21'd10000) % 21'd100;
        rate_new = 6'(quot) + 6'(FAIZ_MARJ);
        all_nz   = (h0_q[g_q] != '0) && (h1_q[g_q] != '0) && (h2_q[g_q] != '0);
    end

    always_ff @(posedge saat) begin
        if (reset) begin
            state_q   <= StBosta;
            g_q       <= '0;
            ptr_q     <= '0;
            p_q       <= '0;
            kabul_q   <= '0;
            gecerli_q <= 1'b0;
            bolge_q   <= '0;
            faiz_q    <= '0;
            mesgul_q  <= 1'b0;
            for (int i = 0; i < int'(BOLGE_SAYISI); i++) begin
                h0_q[i]   <= '0;
                h1_q[i]   <= '0;
                h2_q[i]   <= '0;
                rate_q[i] <= '0;
            end
        end else begin
            kabul_q <= '0;
            unique case (state_q)
                StBosta: begin
                    if (grant_valid) begin
                        h0_q[grant] <= h1_q[grant];
                        h1_q[grant] <= h2_q[grant];
                        h2_q[grant] <= samp[grant];
                        g_q         <= grant;
                        kabul_q     <= {{(BOLGE_SAYISI-1){1'b0}}, 1'b1} << grant;
                        ptr_q       <= ptr_next;
                        mesgul_q    <= 1'b1;
                        state_q     <= StCarp1;
                    end
                end
                StCarp1: begin
                    p_q     <= fac0 * fac1;
                    state_q <= StCarp2;
                end
                StCarp2: begin
                    p_q     <= p_q * fac2;
                    state_q <= StBol;
                end
                StBol: begin
                    // A zero anywhere in the history freezes the region's rate.
                    if (all_nz) begin
                        rate_q[g_q] <= rate_new;
                        faiz_q      <= rate_new;
                    end else begin
                        faiz_q      <= rate_q[g_q];
                    end
                    bolge_q   <= g_q;
                    gecerli_q <= 1'b1;
                    state_q   <= StSonuc;
                end
                StSonuc: begin
                    gecerli_q <= 1'b0;
                    mesgul_q  <= 1'b0;
                    state_q   <= StBosta;
                end
                default: state_q <= StBosta;
            endcase
        end
    end

    assign bus.kabul        = kabul_q;
    assign bus.faiz_gecerli = gecerli_q;
    assign bus.faiz_bolge   = bolge_q;
    assign bus.faiz         = faiz_q;
    assign bus.mesgul       = mesgul_q;
endmodule

// File: tb/tb_faiz_hakem.sv
// Directed bench for faiz_hakem: per-region rate sequences, arbitration order, mid-flight reset.
module tb_faiz_hakem;
    logic saat;
    logic reset;
    int   n_cmp;
    int   n_err;

    faiz_hakem_if #(.BOLGE_SAYISI(4)) bus ();

    faiz_hakem #(
        .BOLGE_SAYISI(4),
        .FAIZ_MARJ   (2)
    ) dut (
        .saat (saat),
        .reset(reset),
        .bus  (bus)
    );

    initial saat = 1'b0;
    always #5 saat = ~saat;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        bus.istek = '0;
        reset     = 1'b1;
        @(posedge saat);
        @(posedge saat);
        @(negedge saat);
        chk("rst_kabul", 32'(bus.kabul), 0);
        chk("rst_gecerli", 32'(bus.faiz_gecerli), 0);
        chk("rst_bolge", 32'(bus.faiz_bolge), 0);
        chk("rst_faiz", 32'(bus.faiz), 0);
        chk("rst_mesgul", 32'(bus.mesgul), 0);
        reset = 1'b0;
    endtask

    // Hold istek until kabul, then expect the result three negedges later.
    task automatic send(input int r, input logic [3:0] v, input logic [5:0] exp_faiz);
        int cyc;
        bus.istek[r]           = 1'b1;
        bus.enflasyon[4*r +: 4] = v;
        cyc = 0;
        do begin
            @(negedge saat);
            cyc++;
        end while (!bus.kabul[r] && cyc < 20);
        chk("kabul_onehot", 32'(bus.kabul), 32'(1) << r);
        chk("mesgul_busy", 32'(bus.mesgul), 1);
        bus.istek[r] = 1'b0;
        @(negedge saat);
        chk("gecerli_early", 32'(bus.faiz_gecerli), 0);
        @(negedge saat);
        @(negedge saat);
        chk("gecerli", 32'(bus.faiz_gecerli), 1);
        chk("faiz", 32'(bus.faiz), 32'(exp_faiz));
        chk("faiz_bolge", 32'(bus.faiz_bolge), 32'(r));
        @(negedge saat);
        chk("gecerli_pulse", 32'(bus.faiz_gecerli), 0);
        chk("faiz_hold", 32'(bus.faiz), 32'(exp_faiz));
        chk("mesgul_idle", 32'(bus.mesgul), 0);
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b1;
        bus.istek     = '0;
        bus.enflasyon = '0;

        // 1: region0 1,2,3 -> 0,0,8 (101*102*103 = 1061106)
        do_reset();
        send(0, 4'd1, 6'd0);
        send(0, 4'd2, 6'd0);
        send(0, 4'd3, 6'd8);

        // 2: region1 15,15,15 -> 54 (115^3 = 1520875)
        send(1, 4'd15, 6'd0);
        send(1, 4'd15, 6'd0);
        send(1, 4'd15, 6'd54);

        // 3: region2 5s -> 17 (105^3 = 1157625), zero sample freezes rate
        send(2, 4'd5, 6'd0);
        send(2, 4'd5, 6'd0);
        send(2, 4'd5, 6'd17);
        send(2, 4'd0, 6'd17);
        send(2, 4'd5, 6'd17);
        send(2, 4'd5, 6'd17);
        send(2, 4'd5, 6'd17);

        // 4: all regions requesting -> grants 0,1,2,3,0 every 5 cycles
        do_reset();
        bus.enflasyon = {4'd4, 4'd3, 4'd2, 4'd1};
        bus.istek     = 4'b1111;
        for (int k = 1; k <= 21; k++) begin
            @(negedge saat);
            if (k % 5 == 1) chk("rr_kabul", 32'(bus.kabul), 32'(1) << (((k - 1) / 5) % 4));
            else            chk("rr_kabul_idle", 32'(bus.kabul), 0);
            chk("rr_mesgul", 32'(bus.mesgul), (k % 5 == 0) ? 0 : 1);
        end
        bus.istek = '0;
        for (int k = 0; k < 6; k++) @(negedge saat);
        chk("rr_drain", 32'(bus.mesgul), 0);

        // 5: reset while region3 is in CARP2
        do_reset();
        bus.istek[3]          = 1'b1;
        bus.enflasyon[15:12]  = 4'd7;
        @(negedge saat);
        chk("r5_kabul", 32'(bus.kabul), 32'b1000);
        bus.istek[3] = 1'b0;
        @(negedge saat);
        reset = 1'b1;
        @(negedge saat);
        chk("r5_kabul0", 32'(bus.kabul), 0);
        chk("r5_gecerli0", 32'(bus.faiz_gecerli), 0);
        chk("r5_bolge0", 32'(bus.faiz_bolge), 0);
        chk("r5_faiz0", 32'(bus.faiz), 0);
        chk("r5_mesgul0", 32'(bus.mesgul), 0);
        reset = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge saat);
            chk("r5_no_gecerli", 32'(bus.faiz_gecerli), 0);
        end
        send(3, 4'd1, 6'd0);
        send(3, 4'd2, 6'd0);
        send(3, 4'd3, 6'd8);

        // 6: interleaved region0 and region1 (109^3 = 1295029 -> 31)
        do_reset();
        send(0, 4'd1, 6'd0);
        send(1, 4'd9, 6'd0);
        send(0, 4'd2, 6'd0);
        send(1, 4'd9, 6'd0);
        send(0, 4'd3, 6'd8);
        send(1, 4'd9, 6'd31);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
